// File: rtl/reset_sequencer.sv
// Power/reset sequencer: synchronises and debounces the raw switches, holds all
// resets for HOLD cycles, then releases N_OUT active-low resets in ascending order.
module reset_sequencer #(
  parameter int N_OUT    = 3,
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 16,
  parameter int STAGGER  = 2,
  parameter int CW       = 8
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             on_switch,
  input  logic             reset_switch,
  output logic [N_OUT-1:0] rst_out_,
  output logic             all_ready,
  output logic [1:0]       state
);

  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0]    LAST = IW'(N_OUT - 1);
  localparam logic [N_OUT-1:0] ONE  = N_OUT'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HOLD = 2'd1,
    ST_REL  = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_db;
  logic       w_on_db;
  logic       w_rst_db;

  assign w_raw    = {reset_switch, on_switch};
  assign w_on_db  = r_db[0];
  assign w_rst_db = r_db[1];

  // Stage 1: two-flop synchroniser and debounce, one lane per switch
  for (genvar g = 0; g < 2; g++) begin : g_sw
    logic [CW-1:0] r_dcnt;

    always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
        r_sync1[g] <= 1'b0;
        r_sync2[g] <= 1'b0;
        r_db[g]    <= 1'b0;
        r_dcnt     <= '0;
      end else begin
        r_sync1[g] <= w_raw[g];
        r_sync2[g] <= r_sync1[g];
        if (r_sync2[g] == r_db[g]) begin
          r_dcnt <= '0;
        end else if (r_dcnt == CW'(DEBOUNCE - 1)) begin
          r_db[g] <= r_sync2[g];
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + CW'(1);
        end
      end
    end
  end

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [N_OUT-1:0] r_rst, w_rst_nxt;
  logic             r_rdy, w_rdy_nxt;

  // Stage 2: sequencing FSM driven by the debounced levels
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rst   <= w_rst_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst;
    w_rdy_nxt   = r_rdy;
    // Power loss outranks the reset button, which outranks normal progression
    if (r_state != ST_OFF && !w_on_db) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '0;
      w_rdy_nxt   = 1'b0;
    end else if (r_state != ST_OFF && w_rst_db) begin
      w_state_nxt = ST_HOLD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '0;
      w_rdy_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_rst_nxt = '0;
          w_rdy_nxt = 1'b0;
          if (w_on_db && !w_rst_db) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
          end
        end
        ST_HOLD: begin
          if (r_cnt == CW'(HOLD - 1)) begin
            w_rst_nxt = ONE;
            w_cnt_nxt = '0;
            w_idx_nxt = IW'(1);
            if (N_OUT == 1) begin
              w_state_nxt = ST_RUN;
              w_rdy_nxt   = 1'b1;
            end else begin
              w_state_nxt = ST_REL;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_REL: begin
          if (r_cnt == CW'(STAGGER - 1)) begin
            w_rst_nxt = r_rst | (ONE << r_idx);
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + IW'(1);
            if (r_idx == LAST) begin
              w_state_nxt = ST_RUN;
              w_rdy_nxt   = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_RUN: begin
          w_rdy_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_rst_nxt   = '0;
          w_rdy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign rst_out_  = r_rst;
  assign all_ready = r_rdy;
  assign state     = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three parameterisations share one switch stimulus and
// are checked every cycle against an elapsed-time model plus literal timing points.
module tb_reset_sequencer;

  logic clock;
  logic reset_;
  logic on_switch;
  logic reset_switch;

  logic [2:0] u0_rst;
  logic [0:0] u1_rst;
  logic [4:0] u2_rst;
  logic       u0_rdy, u1_rdy, u2_rdy;
  logic [1:0] u0_st, u1_st, u2_st;

  reset_sequencer #(.N_OUT(3), .DEBOUNCE(4), .HOLD(16), .STAGGER(2), .CW(8)) u0 (
    .clock(clock), .reset_(reset_), .on_switch(on_switch), .reset_switch(reset_switch),
    .rst_out_(u0_rst), .all_ready(u0_rdy), .state(u0_st));

  reset_sequencer #(.N_OUT(1), .DEBOUNCE(1), .HOLD(1), .STAGGER(1), .CW(8)) u1 (
    .clock(clock), .reset_(reset_), .on_switch(on_switch), .reset_switch(reset_switch),
    .rst_out_(u1_rst), .all_ready(u1_rdy), .state(u1_st));

  reset_sequencer #(.N_OUT(5), .DEBOUNCE(4), .HOLD(16), .STAGGER(3), .CW(8)) u2 (
    .clock(clock), .reset_(reset_), .on_switch(on_switch), .reset_switch(reset_switch),
    .rst_out_(u2_rst), .all_ready(u2_rdy), .state(u2_st));

  logic [7:0] dut_rst [3];
  logic       dut_rdy [3];
  logic [1:0] dut_st  [3];
  assign dut_rst[0] = {5'b0, u0_rst};
  assign dut_rst[1] = {7'b0, u1_rst};
  assign dut_rst[2] = {3'b0, u2_rst};
  assign dut_rdy[0] = u0_rdy;
  assign dut_rdy[1] = u1_rdy;
  assign dut_rdy[2] = u2_rdy;
  assign dut_st[0]  = u0_st;
  assign dut_st[1]  = u1_st;
  assign dut_st[2]  = u2_st;

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
    end
  endtask

  // Model: debounce as "last DEBOUNCE synced samples all opposite to the accepted
  // level"; sequencing as elapsed cycles since HOLD entry, bit k free at HOLD+k*STAGGER.
  int P_N [3] = '{3, 1, 5};
  int P_D [3] = '{4, 1, 4};
  int P_H [3] = '{16, 1, 16};
  int P_S [3] = '{2, 1, 3};

  logic        m_on_q1 = 0, m_on_q2 = 0, m_rs_q1 = 0, m_rs_q2 = 0;
  logic        m_on_db [3] = '{0, 0, 0};
  logic        m_rs_db [3] = '{0, 0, 0};
  logic [15:0] m_on_h  [3] = '{0, 0, 0};
  logic [15:0] m_rs_h  [3] = '{0, 0, 0};
  bit          m_act   [3] = '{0, 0, 0};
  int          m_t     [3] = '{0, 0, 0};

  function automatic bit settled(input logic [15:0] h, input int d, input logic v);
    logic [15:0] msk;
    msk = 16'((32'd1 << d) - 1);
    return (h & msk) == (v ? msk : 16'd0);
  endfunction

  task automatic model_reset();
    m_on_q1 = 0; m_on_q2 = 0; m_rs_q1 = 0; m_rs_q2 = 0;
    for (int i = 0; i < 3; i++) begin
      m_on_db[i] = 0; m_rs_db[i] = 0; m_on_h[i] = 0; m_rs_h[i] = 0;
      m_act[i] = 0; m_t[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!m_act[i]) begin
        if (m_on_db[i] && !m_rs_db[i]) begin m_act[i] = 1; m_t[i] = 0; end
      end else if (!m_on_db[i]) m_act[i] = 0;
      else if (m_rs_db[i]) m_t[i] = 0;
      else if (m_t[i] < 100000) m_t[i]++;
      m_on_h[i] = {m_on_h[i][14:0], m_on_q2};
      m_rs_h[i] = {m_rs_h[i][14:0], m_rs_q2};
      if (settled(m_on_h[i], P_D[i], !m_on_db[i])) m_on_db[i] = !m_on_db[i];
      if (settled(m_rs_h[i], P_D[i], !m_rs_db[i])) m_rs_db[i] = !m_rs_db[i];
    end
    m_on_q2 = m_on_q1; m_on_q1 = on_switch;
    m_rs_q2 = m_rs_q1; m_rs_q1 = reset_switch;
  endtask

  function automatic logic [7:0] exp_rst(input int i);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < P_N[i]; k++)
      if (m_act[i] && m_t[i] >= P_H[i] + k * P_S[i]) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_rdy(input int i);
    return m_act[i] && (m_t[i] >= P_H[i] + (P_N[i] - 1) * P_S[i]);
  endfunction

  function automatic logic [1:0] exp_st(input int i);
    if (!m_act[i]) return 2'd0;
    if (m_t[i] < P_H[i]) return 2'd1;
    if (exp_rdy(i)) return 2'd3;
    return 2'd2;
  endfunction

  always @(posedge clock or negedge reset_) begin
    if (!reset_) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cyc_rst_u%0d", i), 32'(dut_rst[i]), 32'(exp_rst(i)));
        chk($sformatf("cyc_rdy_u%0d", i), 32'(dut_rdy[i]), 32'(exp_rdy(i)));
        chk($sformatf("cyc_st_u%0d", i),  32'(dut_st[i]),  32'(exp_st(i)));
      end
    end
  end

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic at(input int n);
    while (e < n) begin
      @(posedge clock);
      e++;
    end
    #1;
  endtask

  task automatic chk_u0(input string nm, input logic [2:0] r, input logic rdy, input logic [1:0] st);
    chk({nm, "_rst"}, 32'(u0_rst), 32'(r));
    chk({nm, "_rdy"}, 32'(u0_rdy), 32'(rdy));
    chk({nm, "_st"},  32'(u0_st),  32'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_ = 1; on_switch = 0; reset_switch = 0;
    #1 reset_ = 0;
    #2;
    cmp_en = 1;
    chk_u0("reset", 3'b000, 1'b0, 2'd0);
    chk("reset_u2_rst", 32'(u2_rst), 32'h0);
    #9;
    reset_ = 1; on_switch = 1;

    at(4);  chk("pwr_u1_st4", 32'(u1_st), 32'd1);
    at(5);  chk("pwr_u1_rst5", 32'(u1_rst), 32'd1);
            chk("pwr_u1_rdy5", 32'(u1_rdy), 32'd1);
            chk("pwr_u1_st5",  32'(u1_st),  32'd3);
    at(6);  chk_u0("pwr_e6", 3'b000, 1'b0, 2'd0);
    at(7);  chk_u0("pwr_e7", 3'b000, 1'b0, 2'd1);
    at(22); chk_u0("pwr_e22", 3'b000, 1'b0, 2'd1);
    at(23); chk_u0("pwr_e23", 3'b001, 1'b0, 2'd2);
            chk("pwr_u2_e23", 32'(u2_rst), 32'h01);
    at(25); chk_u0("pwr_e25", 3'b011, 1'b0, 2'd2);
    at(26); chk("pwr_u2_e26", 32'(u2_rst), 32'h03);
    at(27); chk_u0("pwr_e27", 3'b111, 1'b1, 2'd3);

    at(30); reset_switch = 1;
    at(32); chk("pwr_u2_e32", 32'(u2_rst), 32'h0F);
            chk("pwr_u2_st32", 32'(u2_st), 32'd2);
    at(33); reset_switch = 0;
    at(35); chk("pwr_u2_e35", 32'(u2_rst), 32'h1F);
            chk("pwr_u2_rdy35", 32'(u2_rdy), 32'd1);
    at(40); chk_u0("glitch_e40", 3'b111, 1'b1, 2'd3);
            reset_switch = 1;
    at(46); chk_u0("press_e46", 3'b111, 1'b1, 2'd3);
    at(47); chk_u0("press_e47", 3'b000, 1'b0, 2'd1);
    at(50); reset_switch = 0;

    at(66); reset_switch = 1;
    at(70); reset_switch = 0;
    at(71); chk_u0("abort_e71", 3'b000, 1'b0, 2'd1);
    at(72); chk_u0("abort_e72", 3'b001, 1'b0, 2'd2);
    at(73); chk_u0("abort_e73", 3'b000, 1'b0, 2'd1);
    at(91); chk_u0("abort_e91", 3'b000, 1'b0, 2'd1);
    at(92); chk_u0("abort_e92", 3'b001, 1'b0, 2'd2);
    at(96); chk_u0("abort_e96", 3'b111, 1'b1, 2'd3);

    at(100); reset_switch = 1;
    at(107); chk_u0("prio_e107", 3'b000, 1'b0, 2'd1);
    at(110); on_switch = 0;
    at(112); reset_switch = 0;
    at(116); chk_u0("prio_e116", 3'b000, 1'b0, 2'd1);
    at(117); chk_u0("prio_e117", 3'b000, 1'b0, 2'd0);

    at(120); on_switch = 1;
    at(127); chk_u0("rep_e127", 3'b000, 1'b0, 2'd1);
    at(143); chk_u0("rep_e143", 3'b001, 1'b0, 2'd2);
    at(144); #2 reset_ = 0;
    #1;
    chk_u0("async", 3'b000, 1'b0, 2'd0);
    chk("async_u2_rst", 32'(u2_rst), 32'h0);
    #1 reset_ = 1;
    at(151); chk_u0("post_e151", 3'b000, 1'b0, 2'd1);
    at(167); chk_u0("post_e167", 3'b001, 1'b0, 2'd2);
    at(171); chk_u0("post_e171", 3'b111, 1'b1, 2'd3);

    at(175); on_switch = 0;
    at(181); chk_u0("off_e181", 3'b111, 1'b1, 2'd3);
    at(182); chk_u0("off_e182", 3'b000, 1'b0, 2'd0);
    at(190);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
